// File: rtl/dp_segs_writer.sv
// ============================================================================
// dp_segs_writer
// ----------------------------------------------------------------------------
// Turns an AXI-Stream packet into the segment-write bus used by the header
// lookup stage. The first HDR_SEGS segments (the header) are always written:
// short packets are padded with zero segments, and long packets are cut off
// after SEG_NUM segments. Any beats past that point are accepted and dropped.
// After the last segment of every packet, s_axis_tready is held low for
// GAP_CYCLES cycles. This gives the downstream 4-phase bit-collection FSM
// time to finish.
//
// Optional build macro: DP_SEGS_WRITER_STATS_EN
//   defined   : o_trunc_cnt / o_pad_cnt count truncated / padded packets
//               (16-bit, saturating).
//   undefined : both counters are tied to zero.
//   Segment output and FSM timing are identical in both builds.
//
// Ports
//   axis_clk         in   clock
//   areset           in   asynchronous reset, active-high
//   s_axis_tdata     in   input beat
//   s_axis_tvalid    in   beat valid
//   s_axis_tlast     in   last beat of packet
//   s_axis_tready    out  beat accepted when tvalid & tready (registered)
//   o_dp_segs_tdata  out  segment data (0 when no segment)
//   o_dp_segs_valid  out  segment present this cycle
//   o_dp_segs_wea    out  segment write enable
//   o_dp_segs_addra  out  segment index (all-ones when no segment)
//   o_pkt_done       out  1-cycle pulse with the final segment of a packet
//   o_trunc_cnt      out  truncated-packet count
//   o_pad_cnt        out  padded-packet count
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for the first beat of a packet
//   WRITE  | writing segments 1..SEG_NUM-1 from incoming beats
//   DRAIN  | segment limit reached; swallow beats until tlast
//   PAD    | emitting zero segments up to HDR_SEGS-1
//   GAP    | tready low for GAP_CYCLES cycles before the next packet
// ============================================================================
module dp_segs_writer #(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int SEG_ADDR          = 3,
    parameter int SEG_NUM           = 8,
    parameter int HDR_SEGS          = 4,
    parameter int GAP_CYCLES        = 4
) (
    input  logic                         axis_clk,
    input  logic                         areset,
    input  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0] o_dp_segs_tdata,
    output logic                         o_dp_segs_valid,
    output logic                         o_dp_segs_wea,
    output logic [SEG_ADDR-1:0]          o_dp_segs_addra,
    output logic                         o_pkt_done,
    output logic [15:0]                  o_trunc_cnt,
    output logic [15:0]                  o_pad_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_PAD   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    // One extra bit so the segment counter can hold SEG_NUM itself.
    localparam int CNT_W = SEG_ADDR + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] HDR_SEGS_C = CNT_W'(HDR_SEGS);
    localparam logic [CNT_W-1:0] HDR_LAST_C = CNT_W'(HDR_SEGS - 1);
    localparam logic [CNT_W-1:0] SEG_NUM_C  = CNT_W'(SEG_NUM);
    localparam logic [GAP_W-1:0] GAP_LOAD_C = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_TC_C   = GAP_W'(1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;

    logic [CNT_W-1:0] seg_idx, idx_inc;

    logic                         seg_valid_nxt;
    logic [C_AXIS_DATA_WIDTH-1:0] seg_data_nxt;
    logic [SEG_ADDR-1:0]          seg_addr_nxt;
    logic                         done_nxt;
    logic                         tready_nxt;

    logic accept;

    // tready is a register, so it is low for the first cycle after reset
    // even though the FSM is already in IDLE.
    assign accept = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gap_nxt       = gap_cnt;
        seg_idx       = '0;
        idx_inc       = '0;
        seg_valid_nxt = 1'b0;
        seg_data_nxt  = '0;
        seg_addr_nxt  = '1;
        done_nxt      = 1'b0;

        case (state)
            S_IDLE, S_WRITE: begin
                if (accept) begin
                    // The first beat always lands at index 0, no matter what
                    // an aborted earlier packet left in cnt.
                    seg_idx       = (state == S_IDLE) ? '0 : cnt;
                    idx_inc       = seg_idx + 1'b1;
                    seg_valid_nxt = 1'b1;
                    seg_data_nxt  = s_axis_tdata;
                    seg_addr_nxt  = seg_idx[SEG_ADDR-1:0];
                    cnt_nxt       = idx_inc;
                    if (s_axis_tlast) begin
                        if (idx_inc < HDR_SEGS_C) begin
                            state_nxt = S_PAD;
                        end else begin
                            state_nxt = S_GAP;
                            done_nxt  = 1'b1;
                            gap_nxt   = GAP_LOAD_C;
                        end
                    end else if (idx_inc == SEG_NUM_C) begin
                        // The segment limit is reached and more beats follow,
                        // so this is the final written segment.
                        state_nxt = S_DRAIN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_WRITE;
                    end
                end
            end

            S_DRAIN: begin
                if (accept && s_axis_tlast) begin
                    state_nxt = S_GAP;
                    gap_nxt   = GAP_LOAD_C;
                end
            end

            S_PAD: begin
                seg_valid_nxt = 1'b1;
                seg_addr_nxt  = cnt[SEG_ADDR-1:0];
                cnt_nxt       = cnt + 1'b1;
                if (cnt == HDR_LAST_C) begin
                    state_nxt = S_GAP;
                    done_nxt  = 1'b1;
                    gap_nxt   = GAP_LOAD_C;
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_TC_C) begin
                    state_nxt = S_IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        tready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_WRITE) ||
                     (state_nxt == S_DRAIN);
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            gap_cnt         <= '0;
            s_axis_tready   <= 1'b0;
            o_dp_segs_tdata <= '0;
            o_dp_segs_valid <= 1'b0;
            o_dp_segs_wea   <= 1'b0;
            o_dp_segs_addra <= '1;
            o_pkt_done      <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            gap_cnt         <= gap_nxt;
            s_axis_tready   <= tready_nxt;
            o_dp_segs_tdata <= seg_data_nxt;
            o_dp_segs_valid <= seg_valid_nxt;
            o_dp_segs_wea   <= seg_valid_nxt;
            o_dp_segs_addra <= seg_addr_nxt;
            o_pkt_done      <= done_nxt;
        end
    end

`ifdef DP_SEGS_WRITER_STATS_EN
    logic        trunc_evt;
    logic        pad_evt;
    logic [15:0] trunc_cnt_r;
    logic [15:0] pad_cnt_r;

    assign trunc_evt = (state == S_DRAIN) && (state_nxt == S_GAP);
    assign pad_evt   = (state != S_PAD) && (state_nxt == S_PAD);

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            trunc_cnt_r <= 16'd0;
            pad_cnt_r   <= 16'd0;
        end else begin
            if (trunc_evt && (trunc_cnt_r != 16'hFFFF)) begin
                trunc_cnt_r <= trunc_cnt_r + 16'd1;
            end
            if (pad_evt && (pad_cnt_r != 16'hFFFF)) begin
                pad_cnt_r <= pad_cnt_r + 16'd1;
            end
        end
    end

    assign o_trunc_cnt = trunc_cnt_r;
    assign o_pad_cnt   = pad_cnt_r;
`else
    assign o_trunc_cnt = 16'd0;
    assign o_pad_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_dp_segs_writer.sv
module tb_dp_segs_writer;

    localparam int DW = 256;
    localparam int SA = 3;
    localparam int SN = 8;
    localparam int HS = 4;
    localparam int GC = 4;

    logic          axis_clk = 1'b0;
    logic          areset   = 1'b1;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast  = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] o_dp_segs_tdata;
    logic          o_dp_segs_valid;
    logic          o_dp_segs_wea;
    logic [SA-1:0] o_dp_segs_addra;
    logic          o_pkt_done;
    logic [15:0]   o_trunc_cnt;
    logic [15:0]   o_pad_cnt;

    dp_segs_writer #(
        .C_AXIS_DATA_WIDTH(DW), .SEG_ADDR(SA), .SEG_NUM(SN),
        .HDR_SEGS(HS), .GAP_CYCLES(GC)
    ) dut (
        .axis_clk(axis_clk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .o_dp_segs_tdata(o_dp_segs_tdata), .o_dp_segs_valid(o_dp_segs_valid),
        .o_dp_segs_wea(o_dp_segs_wea), .o_dp_segs_addra(o_dp_segs_addra),
        .o_pkt_done(o_pkt_done), .o_trunc_cnt(o_trunc_cnt), .o_pad_cnt(o_pad_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        logic          done;
    } seg_t;

    seg_t exp_q[$];
    int   run_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pad_exp   = 0;
    int   trunc_exp = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: a packet of n beats writes min(n,SN) data segments,
    // zero-padded up to HS, with done on the final one. Afterwards, tready
    // stays low for the pad segments plus the gap.
    task automatic model_pkt(input logic [DW-1:0] d [16], input int n);
        int   nw;
        int   total;
        seg_t s;
        nw    = (n < SN) ? n : SN;
        total = (nw < HS) ? HS : nw;
        for (int i = 0; i < total; i++) begin
            s.addr = i;
            s.data = (i < nw) ? d[i] : '0;
            s.done = (i == total - 1);
            exp_q.push_back(s);
        end
        run_q.push_back(GC + ((n < HS) ? HS - n : 0));
        if (n < HS) pad_exp++;
        if (n > SN) trunc_exp++;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int guard;
        guard = 0;
        @(negedge axis_clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        while (!s_axis_tready && guard < 100) begin
            @(negedge axis_clk);
            guard++;
        end
        if (!s_axis_tready) chk("tready_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge axis_clk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tdata  = rand_beat();
        end
    endtask

    // pattern: 0 random, 1 all 0xAA bytes, 2 counting values 1..n
    task automatic send_pkt(input int n, input int pattern, input int bub_at,
                            input int bub_len, input bit rnd_bub);
        logic [DW-1:0] d [16];
        logic [DW-1:0] aa;
        aa = {(DW/8){8'hAA}};
        for (int i = 0; i < 16; i++) begin
            case (pattern)
                1:       d[i] = aa;
                2:       d[i] = DW'(i + 1);
                default: d[i] = rand_beat();
            endcase
        end
        model_pkt(d, n);
        for (int i = 0; i < n; i++) begin
            send_beat(d[i], (i == n - 1));
            if (i == bub_at) idle(bub_len);
            else if (rnd_bub && i != n - 1 && $urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge axis_clk);
            g++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (GC + 6) @(negedge axis_clk);
    endtask

    task automatic check_stats();
`ifdef DP_SEGS_WRITER_STATS_EN
        chk("pad_cnt", o_pad_cnt, pad_exp);
        chk("trunc_cnt", o_trunc_cnt, trunc_exp);
`else
        chk("pad_cnt", o_pad_cnt, 0);
        chk("trunc_cnt", o_trunc_cnt, 0);
`endif
    endtask

    // Output monitor
    initial begin
        int   run_len;
        bit   ign;
        seg_t e;
        run_len = 0;
        ign     = 1'b1;
        forever begin
            @(negedge axis_clk);
            if (areset) begin
                run_len = 0;
                ign     = 1'b1;
            end else if (!s_axis_tready) begin
                run_len++;
            end else begin
                if (run_len > 0 && !ign) begin
                    if (run_q.size() == 0) chk("tready_run_unexpected", run_len, 0);
                    else chk("tready_low_run", run_len, run_q.pop_front());
                end
                ign     = 1'b0;
                run_len = 0;
            end
            if (o_dp_segs_valid) begin
                if (exp_q.size() == 0) begin
                    chk("seg_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("seg_addr", o_dp_segs_addra, e.addr);
                    chk("seg_data", o_dp_segs_tdata, e.data);
                    chk("seg_wea", o_dp_segs_wea, 1);
                    chk("pkt_done", o_pkt_done, e.done);
                end
            end else begin
                chk("idle_addra", o_dp_segs_addra, {SA{1'b1}});
                chk("idle_tdata", o_dp_segs_tdata, 0);
                chk("idle_wea", o_dp_segs_wea, 0);
                chk("idle_done", o_pkt_done, 0);
            end
        end
    end

    initial begin
        logic [DW-1:0] d [16];
        logic [DW-1:0] r [16];

        // Reset values
        repeat (3) @(negedge axis_clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_valid", o_dp_segs_valid, 0);
        chk("rst_addra", o_dp_segs_addra, {SA{1'b1}});
        chk("rst_tdata", o_dp_segs_tdata, 0);
        chk("rst_trunc", o_trunc_cnt, 0);
        chk("rst_pad", o_pad_cnt, 0);
        #2 areset = 1'b0;

        // 1: four-beat packet, no padding/truncation
        send_pkt(4, 2, -1, 0, 0);
        idle(1);
        wait_idle();
        check_stats();

        // 2: single-beat packet, padded to header
        send_pkt(1, 1, -1, 0, 0);
        idle(1);
        wait_idle();
        check_stats();

        // 3: eleven beats, truncated at SN
        send_pkt(11, 0, -1, 0, 0);
        idle(1);
        wait_idle();
        check_stats();

        // Exactly SN beats: not truncated
        send_pkt(SN, 0, -1, 0, 0);
        idle(1);
        wait_idle();
        check_stats();

        // 4: six beats with a 2-cycle bubble after beat 2
        send_pkt(6, 0, 1, 2, 0);
        idle(1);
        wait_idle();
        check_stats();

        // 5: reset in the middle of a 5-beat packet
        for (int i = 0; i < 16; i++) d[i] = rand_beat();
        model_pkt(d, 5);
        send_beat(d[0], 1'b0);
        send_beat(d[1], 1'b0);
        @(negedge axis_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #2 areset = 1'b1;
        #1;
        chk("arst_valid", o_dp_segs_valid, 0);
        chk("arst_wea", o_dp_segs_wea, 0);
        chk("arst_addra", o_dp_segs_addra, {SA{1'b1}});
        chk("arst_tdata", o_dp_segs_tdata, 0);
        chk("arst_done", o_pkt_done, 0);
        chk("arst_tready", s_axis_tready, 0);
        exp_q.delete();
        run_q.delete();
        pad_exp   = 0;
        trunc_exp = 0;
        repeat (2) @(negedge axis_clk);
        #2 areset = 1'b0;
        for (int i = 0; i < 16; i++) r[i] = '0;
        r[0] = d[3];
        r[1] = d[4];
        model_pkt(r, 2);
        send_beat(r[0], 1'b0);
        send_beat(r[1], 1'b1);
        idle(1);
        wait_idle();
        check_stats();

        // 6: back-to-back packets, tvalid held high across the gaps
        send_pkt(4, 0, -1, 0, 0);
        send_pkt(2, 0, -1, 0, 0);
        send_pkt(10, 0, -1, 0, 0);
        send_pkt(5, 0, -1, 0, 0);
        idle(1);
        wait_idle();
        check_stats();

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 12), 0, -1, 0, 1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 6));
        end
        idle(1);
        wait_idle();
        check_stats();

        chk("exp_q_empty", exp_q.size(), 0);
        chk("run_q_empty", run_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
